// File: rtl/quad_counter.sv
`default_nettype none
// ============================================================================
// quad_counter : sync, glitch-filter and 4x decode of an A/B/Z encoder,
//                with wrapping position count, index latch and SPI snapshot.
// Rev 1.0
// ============================================================================
module quad_counter #(
  parameter int W    = 16,
  parameter int FILT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         enc_a,
  input  logic         enc_b,
  input  logic         enc_z,
  input  logic         snap,
  input  logic         clr,
  output logic [W-1:0] count_snap,
  output logic [W-1:0] idx_pos,
  output logic         idx_seen,
  output logic         err
);

  localparam int            CW       = 4;
  localparam logic [CW-1:0] FILT_TOP = CW'(FILT);

  // Bit order for the three channels: 0 = A, 1 = B, 2 = Z
  logic [2:0]   raw;
  logic [2:0]   sync1;
  logic [2:0]   sync2;
  logic [2:0]   filt;

  logic [1:0]   ab_prev;
  logic         z_prev;
  logic [W-1:0] count;

  logic [1:0]   pos_cur;
  logic [1:0]   pos_prev;
  logic [1:0]   delta;
  logic         step_up;
  logic         step_dn;
  logic         illegal;
  logic         z_rise;
  logic [W-1:0] count_next;

  assign raw = {enc_z, enc_b, enc_a};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // A new level is accepted only after FILT consecutive disagreeing ce samples
  generate
    for (genvar i = 0; i < 3; i++) begin : g_filt
      logic [CW-1:0] cnt;
      logic          lvl;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
          lvl <= 1'b0;
        end else if (ce) begin
          if (sync2[i] == lvl) begin
            cnt <= '0;
          end else if (cnt == FILT_TOP - CW'(1)) begin
            cnt <= '0;
            lvl <= sync2[i];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      end

      assign filt[i] = lvl;
    end
  endgenerate

  // Gray {A,B} to binary phase so direction falls out of a 2-bit difference
  assign pos_cur  = {filt[0], filt[0] ^ filt[1]};
  assign pos_prev = {ab_prev[1], ab_prev[1] ^ ab_prev[0]};
  assign delta    = pos_cur - pos_prev;
  assign step_up  = (delta == 2'd1);
  assign step_dn  = (delta == 2'd3);
  assign illegal  = (delta == 2'd2);
  assign z_rise   = filt[2] & ~z_prev;

  always_comb begin
    count_next = count;
    if (step_up) begin
      count_next = count + W'(1);
    end else if (step_dn) begin
      count_next = count - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ab_prev    <= 2'b00;
      z_prev     <= 1'b0;
      count      <= '0;
      count_snap <= '0;
      idx_pos    <= '0;
      idx_seen   <= 1'b0;
      err        <= 1'b0;
    end else begin
      ab_prev <= {filt[0], filt[1]};
      z_prev  <= filt[2];

      // Snapshot always takes the pre-update count, even alongside clr
      if (snap) begin
        count_snap <= count;
      end

      if (clr) begin
        count    <= '0;
        err      <= 1'b0;
        idx_seen <= 1'b0;
      end else begin
        count <= count_next;
        if (illegal) begin
          err <= 1'b1;
        end
        if (z_rise) begin
          idx_pos  <= count_next;
          idx_seen <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
